// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// unit (port A) and the loader/DMA engine (port B).
//   - Round-robin accept stage (combinational gnt), A wins the first tie.
//   - One registered memory stage drives mem_we/mem_addr/mem_wdata.
//   - Read data is captured at the end of the memory stage; rvalid pulses the
//     following cycle on the owning port only.
// Ports:
//   clk, reset          clock, async active-high reset
//   {a,b}_req/we/addr/wdata   request fields, held until gnt
//   {a,b}_gnt           request accepted this cycle
//   {a,b}_rvalid/rdata  read return (rdata held until the next read on that port)
//   mem_we/addr/wdata   to dmem; mem_rdata from dmem (combinational read)
//   busy                memory stage occupied this cycle

module dmem_arb_rport #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk or posedge reset)
    if (reset)    rdata <= '0;
    else if (cap) rdata <= din;
endmodule

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [NUM_PORTS-1:0]                  req;
  req_t                                  win;
  logic [NUM_PORTS-1:0]                  rq, gnt, cap;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata;
  logic                                  prio_b;    // 1: B wins the next tie
  logic [1:0]                            vld_pipe;  // [0] memory stage, [1] read-return slot
  logic                                  st_we, st_port, ret_port;

  assign rq     = {b_req, a_req};
  assign req[0] = {a_we, a_addr, a_wdata};
  assign req[1] = {b_we, b_addr, b_wdata};

  // Priority only matters on a tie; a lone requester is always granted.
  always_comb begin
    gnt[0] = rq[0] & (~rq[1] | ~prio_b);
    gnt[1] = rq[1] & (~rq[0] |  prio_b);
  end

  assign win   = gnt[1] ? req[1] : req[0];
  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Address/data are only loaded on accept so they hold while idle;
  // mem_we (via vld_pipe[0]) is the only write qualifier.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prio_b    <= 1'b0;
      vld_pipe  <= '0;
      st_we     <= 1'b0;
      st_port   <= 1'b0;
      ret_port  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      vld_pipe[0] <= |gnt;
      vld_pipe[1] <= vld_pipe[0] & ~st_we;
      ret_port    <= st_port;
      if (|gnt) begin
        prio_b    <= gnt[0];
        st_we     <= win.we;
        st_port   <= gnt[1];
        mem_addr  <= win.addr;
        mem_wdata <= win.wdata;
      end
    end

  assign mem_we = vld_pipe[0] & st_we;
  assign busy   = vld_pipe[0];

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rport
      assign cap[p] = vld_pipe[0] & ~st_we & (st_port == 1'(p));
      dmem_arb_rport #(.DW(DATA_WIDTH)) u_rport (
        .clk   (clk),
        .reset (reset),
        .cap   (cap[p]),
        .din   (mem_rdata),
        .rdata (rdata[p])
      );
    end
  endgenerate

  assign a_rdata  = rdata[0];
  assign b_rdata  = rdata[1];
  assign a_rvalid = vld_pipe[1] & ~ret_port;
  assign b_rvalid = vld_pipe[1] &  ret_port;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural dmem plus a transaction-level reference
// (grant-order memory image, timed queue of expected read returns).
module tb_dmem_arbiter;
  logic        clk, reset;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] dmem   [0:65535];
  logic [15:0] refmem [0:65535];

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct { int due; bit port; logic [15:0] data; } rd_t;
  rd_t         q[$];
  int          checks, errors, cyc;
  bit          last_b, e_we, e_busy;
  logic [15:0] e_addr, e_wdata, e_ard, e_brd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_b = 1'b1;  // as if B was served last, so A wins the first tie
    e_we = 0; e_busy = 0; e_addr = 0; e_wdata = 0; e_ard = 0; e_brd = 0;
    q.delete();
  endtask

  // One clock cycle: drive at posedge+1, check mid-cycle, advance model, step.
  task automatic cyc_step(input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                          input bit br, input bit bw, input logic [15:0] ba, input logic [15:0] bd,
                          output bit ga, output bit gb);
    bit          earv, ebrv, we;
    logic [15:0] ad_sel, wd_sel;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    earv = 0; ebrv = 0; we = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].port) begin ebrv = 1; e_brd = q[0].data; end
      else           begin earv = 1; e_ard = q[0].data; end
      q.delete(0);
    end
    if (ar && br) begin ga = last_b; gb = !last_b; end
    else          begin ga = ar;     gb = br;      end
    #4;
    chk("a_gnt",     16'(a_gnt),    16'(ga));
    chk("b_gnt",     16'(b_gnt),    16'(gb));
    chk("mem_we",    16'(mem_we),   16'(e_we));
    chk("busy",      16'(busy),     16'(e_busy));
    chk("mem_addr",  mem_addr,      e_addr);
    chk("mem_wdata", mem_wdata,     e_wdata);
    chk("a_rvalid",  16'(a_rvalid), 16'(earv));
    chk("b_rvalid",  16'(b_rvalid), 16'(ebrv));
    chk("a_rdata",   a_rdata,       e_ard);
    chk("b_rdata",   b_rdata,       e_brd);
    if (ga || gb) begin
      last_b = gb;
      we     = gb ? bw : aw;
      ad_sel = gb ? ba : aa;
      wd_sel = gb ? bd : ad;
      if (we) refmem[ad_sel] = wd_sel;
      else    q.push_back('{cyc + 2, gb, refmem[ad_sel]});
      e_addr = ad_sel; e_wdata = wd_sel;
    end
    e_we = (ga || gb) && we;
    e_busy = ga || gb;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int k = 0; k < n; k++) cyc_step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, ga, gb);
  endtask

  initial begin
    bit          ga, gb, pa, pb, paw, pbw;
    logic [15:0] paa, pad, pba, pbd;
    logic [3:0]  v;
    int          na, nb;
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

    // Reset state
    #20;
    chk("rst_mem_we",   16'(mem_we),   16'h0);
    chk("rst_busy",     16'(busy),     16'h0);
    chk("rst_a_rvalid", 16'(a_rvalid), 16'h0);
    chk("rst_b_rvalid", 16'(b_rvalid), 16'h0);
    chk("rst_a_rdata",  a_rdata,       16'h0);
    chk("rst_b_rdata",  b_rdata,       16'h0);
    chk("rst_mem_addr", mem_addr,      16'h0);
    #7 reset = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Idle after reset
    idle(3);

    // Preload through B (DMA role)
    for (int i = 0; i <= 32; i++) cyc_step(0, 0, 16'h0, 16'h0, 1, 1, 16'(i), 16'($urandom), ga, gb);
    cyc_step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0050, 16'h5A5A, ga, gb);

    // A write then read of 0x000E
    cyc_step(1, 1, 16'h000E, 16'h000E, 0, 0, 16'h0, 16'h0, ga, gb);
    cyc_step(1, 0, 16'h000E, 16'h0,    0, 0, 16'h0, 16'h0, ga, gb);
    idle(2);
    chk("t2_a_rdata", a_rdata, 16'h000E);

    // Both ports read every cycle: strict alternation
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, ga, gb);
      na += int'(ga); nb += int'(gb);
    end
    idle(2);
    chk("t3_a_count", 16'(na), 16'd4);
    chk("t3_b_count", 16'(nb), 16'd4);

    // B write then A read-after-write
    cyc_step(0, 0, 16'h0,    16'h0, 1, 1, 16'h0040, 16'h1234, ga, gb);
    cyc_step(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0,    16'h0,    ga, gb);
    idle(2);
    chk("t4_a_rdata", a_rdata, 16'h1234);

    // Reset during the memory stage of a write
    cyc_step(1, 1, 16'h0050, 16'hBEEF, 0, 0, 16'h0, 16'h0, ga, gb);
    a_req = 0; b_req = 0;
    #2;
    chk("t5_we_pre", 16'(mem_we), 16'h1);
    reset = 1'b1;
    #1;
    chk("t5_we_rst",   16'(mem_we), 16'h0);
    chk("t5_busy_rst", 16'(busy),   16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    refmem[16'h0050] = 16'h5A5A;  // the in-flight write never committed
    cyc_step(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0, ga, gb);
    idle(2);
    chk("t5_a_rdata", a_rdata, 16'h5A5A);

    // Every {req_a, req_b, we_a, we_b} combination
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      cyc_step(v[3], v[1], 16'(i), 16'(16'h1000 + i), v[2], v[0], 16'(i + 16), 16'(16'h2000 + i), ga, gb);
    end

    // Random traffic; requests are held until granted or legally dropped
    pa = 0; pb = 0; paw = 0; pbw = 0; paa = 0; pad = 0; pba = 0; pbd = 0;
    for (int i = 0; i < 400; i++) begin
      if (pa && ($urandom % 8 == 0)) pa = 0;
      if (pb && ($urandom % 8 == 0)) pb = 0;
      if (!pa) begin
        pa = ($urandom % 4) != 0; paw = 1'($urandom % 2);
        paa = 16'($urandom % 33); pad = 16'($urandom);
      end
      if (!pb) begin
        pb = ($urandom % 4) != 0; pbw = 1'($urandom % 2);
        pba = 16'($urandom % 33); pbd = 16'($urandom);
      end
      cyc_step(pa, paw, paa, pad, pb, pbw, pba, pbd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
